// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: state encoding, reset PC
// default and the sequential-PC helper.
package pc_sequencer_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  // Address of the next sequential instruction; wraps naturally at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: branch (PC+4 + offset*4) or jump (region
// concatenation). A jump takes priority when both are requested.
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] redir_pc,
  input  logic [31:0] br_offset,
  input  logic [25:0] jmp_index,
  input  logic        jmp,
  output logic [31:0] target
);

  logic [31:0] link_pc;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign link_pc    = pc_plus4(redir_pc);
  // The shift drops offset bits 31:30, matching a 30-bit word offset.
  assign br_target  = link_pc + (br_offset << 2);
  assign jmp_target = {link_pc[31:28], jmp_index, 2'b00};
  assign target     = jmp ? jmp_target : br_target;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the result
// for decode, and handles branch/jump redirects including in-flight discards.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic [31:0] redir_pc,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_index
);

  seq_state_e  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        redirect;
  logic [31:0] redir_target;

  assign redirect = jmp | br_taken;

  pc_target_calc u_target (
    .redir_pc  (redir_pc),
    .br_offset (br_offset),
    .jmp_index (jmp_index),
    .jmp       (jmp),
    .target    (redir_target)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    discard_d  = discard_q;
    pend_pc_d  = pend_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        fetch_pc_d = RESET_PC;
      end

      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            fetch_pc_d = redir_target;
            discard_d  = 1'b0;
          end else if (discard_q) begin
            // Stale data from before the redirect; now go to the saved target.
            fetch_pc_d = pend_pc_q;
            discard_d  = 1'b0;
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          // Request stays on the bus until acked; a later redirect overwrites.
          discard_d = 1'b1;
          pend_pc_d = redir_target;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          fetch_pc_d = redir_target;
          state_d    = ST_FETCH;
        end else if (instr_ready) begin
          fetch_pc_d = pc_plus4(pc_q);
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      discard_q  <= 1'b0;
      pend_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stalls, redirects from
// each state, jump priority, PC wrap and mid-fetch reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] redir_pc;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jmp;
  logic [25:0] jmp_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .redir_pc    (redir_pc),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jmp         (jmp),
    .jmp_index   (jmp_index)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch with a single wait cycle before the ack; ends in HOLD.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s req/addr: got req=%b addr=%h, want req=1 addr=%h", tag, imem_req, imem_addr, exp_addr);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s addr stable: got req=%b addr=%h, want req=1 addr=%h", tag, imem_req, imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== data || pc_out !== exp_addr) begin
      errors++;
      $display("FAIL %s hold: got valid=%b instr=%h pc=%h, want valid=1 instr=%h pc=%h",
               tag, instr_valid, instr_out, pc_out, data, exp_addr);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr_out !== 32'h0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got req=%b addr=%h valid=%b instr=%h pc=%h, want 0/0/0/0/0",
               imem_req, imem_addr, instr_valid, instr_out, pc_out);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: got req=%b, want 0", imem_req);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_fetch: got req=%b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_fetch("seq", 32'(i * 4), 32'h1000_0000 + 32'(i));
      tick();
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    do_fetch("stall", 32'h0000_000C, 32'hCAFE_000C);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 32'hCAFE_000C || pc_out !== 32'h0000_000C) begin
        errors++;
        $display("FAIL stall_stable: got valid=%b instr=%h pc=%h, want 1 cafe000c 0000000c",
                 instr_valid, instr_out, pc_out);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0010 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%h valid=%b, want 1 00000010 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_branch_hold();
    do_fetch("pre_jmp", 32'h0000_0010, 32'h0000_1110);
    jmp = 1'b1; redir_pc = 32'h0000_0010; jmp_index = 26'h40; instr_ready = 1'b1;
    tick();
    jmp = 1'b0; instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL hold_jmp_drop: got valid=%b addr=%h, want 0 00000100", instr_valid, imem_addr);
    end
    do_fetch("at_100", 32'h0000_0100, 32'h0000_2100);
    br_taken = 1'b1; redir_pc = 32'h0000_0100; br_offset = 32'hFFFF_FFFE; instr_ready = 1'b1;
    tick();
    br_taken = 1'b0; instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_00FC) begin
      errors++;
      $display("FAIL hold_branch: got valid=%b req=%b addr=%h, want 0 1 000000fc", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_fetch();
    jmp = 1'b1; redir_pc = 32'h1000_0040; jmp_index = 26'h10;
    tick();
    jmp = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_00FC) begin
      errors++;
      $display("FAIL pending_addr_held: got req=%b addr=%h, want 1 000000fc", imem_req, imem_addr);
    end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1000_0040) begin
      errors++;
      $display("FAIL discard_then_target: got valid=%b req=%b addr=%h, want 0 1 10000040", instr_valid, imem_req, imem_addr);
    end
    do_fetch("jmp_tgt", 32'h1000_0040, 32'h0000_3040);
  endtask

  task automatic test_jmp_wins();
    jmp = 1'b1; br_taken = 1'b1; redir_pc = 32'h1000_0040; jmp_index = 26'h20; br_offset = 32'h4;
    tick();
    jmp = 1'b0; br_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h1000_0080) begin
      errors++;
      $display("FAIL jmp_priority: got valid=%b addr=%h, want 0 10000080", instr_valid, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0080; br_taken = 1'b1; redir_pc = 32'h1000_0080; br_offset = 32'h2;
    tick();
    imem_ack = 1'b0; br_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1000_008C) begin
      errors++;
      $display("FAIL ack_coincident: got valid=%b req=%b addr=%h, want 0 1 1000008c", instr_valid, imem_req, imem_addr);
    end
    br_taken = 1'b1; redir_pc = 32'h0; br_offset = 32'h10;
    tick();
    br_taken = 1'b0; jmp = 1'b1; jmp_index = 26'h30;
    tick();
    jmp = 1'b0;
    checks++;
    if (imem_addr !== 32'h1000_008C) begin
      errors++;
      $display("FAIL overwrite_held_addr: got addr=%h, want 1000008c", imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_008C;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h0000_00C0) begin
      errors++;
      $display("FAIL overwrite_target: got valid=%b addr=%h, want 0 000000c0", instr_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_fetch("at_c0", 32'h0000_00C0, 32'h0000_40C0);
    br_taken = 1'b1; redir_pc = 32'hFFFF_FFF8; br_offset = 32'h0;
    tick();
    br_taken = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_setup: got addr=%h, want fffffffc", imem_addr);
    end
    do_fetch("top", 32'hFFFF_FFFC, 32'h0000_5FFC);
    instr_ready = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL pc_wrap: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    do_fetch("after_wrap", 32'h0, 32'h0000_6000);
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr_out !== 32'h0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL midfetch_reset: got req=%b addr=%h valid=%b instr=%h pc=%h, want 0/0/0/0/0",
               imem_req, imem_addr, instr_valid, instr_out, pc_out);
    end
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0004;
    jmp = 1'b1; redir_pc = 32'h0; jmp_index = 26'h3FF;
    tick();
    imem_ack = 1'b0; jmp = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignores_idle: got req=%b addr=%h valid=%b, want 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin
      errors++;
      $display("FAIL late_ack_ignored: got valid=%b instr=%h, want 0 00000000", instr_valid, instr_out);
    end
    do_fetch("restart", 32'h0, 32'h0000_7000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redir_pc = '0; br_taken = 1'b0; br_offset = '0; jmp = 1'b0; jmp_index = '0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_hold();
    test_redirect_fetch();
    test_jmp_wins();
    test_back_to_back();
    test_wrap();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
